irq_pending_dispatch: RTL and testbench
=======================================

// Module: irq_pending_dispatch
// PURPOSE
//  Collects N request lines into a sticky pending register, applies a mask and drives the masked
//  vector to the downstream generic priority encoder. Consumes the encoder's valid/index result
//  and issues one registered request ID per transaction over a valid/ready handshake.
//  On acceptance, clears the served pending bit. Sits between raw request sources and a
//  dispatch/service consumer.
// PARAMETERS
//  N    4               number of request lines (>=2)
//  IDW  $clog2(N)       width of request ID (derived; do not override)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous reset, active-low
//  req        in   N    raw request lines, synchronous to clk
//  mask       in   N    1 = line enabled; masked lines still pend but are not offered
//  enc_i      out  N    pending & mask, to encoder input (combinational from registers)
//  enc_v      in   1    encoder valid (|enc_i)
//  enc_y      in   IDW  encoder index; highest set index has priority
//  out_valid  out  1    out_id holds an offered request
//  out_ready  in   1    consumer accepts out_id this cycle
//  out_id     out  IDW  offered request index
//  busy       out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset, synchronous active-low:
//   - pending=0, state=IDLE, out_valid=0, out_id=0, busy=0.
//   - Applies mid-handshake too: an offered ID is dropped with no clear pulse.
//  Pending capture:
//   - pending[k] sets on the cycle after capture (see CONFIGURATION).
//   - Bit is sticky until cleared by acceptance.
//  enc_i = pending & mask; no registering, so the encoder path is purely combinational.
//  FSM states:
//   - IDLE:
//     - if enc_v=1: out_id<=enc_y, out_valid<=1 -> OFFER.
//     - else stay in IDLE.
//   - OFFER:
//     - out_valid=1; out_id held stable regardless of mask/req changes.
//     - on out_valid & out_ready: pending[out_id]<=0, out_valid<=0 -> SETTLE.
//   - SETTLE:
//     - one bubble cycle so enc_i/enc_y reflect the cleared bit -> IDLE.
//  Latency:
//   - req capture to out_valid = 2 cycles minimum (capture, then IDLE->OFFER).
//   - Back-to-back offers are spaced 3 cycles (OFFER accept, SETTLE, IDLE).
//  Boundaries:
//   - A new capture on bit k in the same cycle bit k is cleared: set wins, bit stays pending.
//   - If the mask drops the offered line while in OFFER, the offer still completes and the bit is cleared.
//   - enc_v=0 in IDLE: no offer, out_valid stays 0.
//   - If all lines are pending, the highest index is served first; lower ones follow in descending order
//     unless higher ones re-pend.
//   - enc_y is ignored outside IDLE; enc_y is don't-care when enc_v=0.
// CONFIGURATION
//  IRQ_EDGE_DETECT_EN defined:
//   - Keeps a req_q register (reset 0).
//   - pending[k] sets on a rising edge (req[k] & ~req_q[k]).
//   - A held-high line pends once per edge.
//  Not defined:
//   - Level capture: pending[k] sets whenever req[k]=1.
//   - A held line re-pends immediately after each clear.
// TESTING
//  Bench models the encoder as enc_v=|enc_i, enc_y=highest set index of enc_i.
//  1 Reset: rst_n=0 for 2 cycles with req=4'hF -> out_valid=0, busy=0, enc_i=0 throughout reset.
//  2 Single request, N=4, mask=4'hF: pulse req=4'b0100 for 1 cycle, out_ready=1
//    -> out_valid=1, out_id=2 exactly 2 cycles after the pulse, one beat; then pending=0.
//  3 Priority: req=4'b1011 pulse, out_ready=1
//    -> out_id sequence 3,1,0 with 3-cycle spacing; no repeats (edge mode).
//  4 Backpressure/stability: offer id=3, out_ready=0 for 5 cycles while mask changes to 4'h0
//    -> out_id stays 3, out_valid stays 1; accepted when out_ready=1.
//  5 Collision: edge mode, re-pulse req[1] in the acceptance cycle of id=1
//    -> id=1 offered again after SETTLE/IDLE.
//  6 Mode check: req[0] held high 10 cycles with out_ready=1
//    -> defined: exactly one id=0 offer; undefined: id=0 offered every 3 cycles.
//    Repeat with rst_n=0 asserted mid-OFFER -> out_valid=0 next cycle, pending=0.

Source files
------------

// File: rtl/irq_pending_dispatch.sv
// Sticky request collector with masked priority dispatch over a valid/ready handshake.
// Optional macro IRQ_EDGE_DETECT_EN selects rising-edge capture instead of level capture.

module irq_pending_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    input  logic i_clr,
    output logic o_pend
);
    logic r_pend;
    logic w_set;

`ifdef IRQ_EDGE_DETECT_EN
    logic r_req_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_req_q <= 1'b0;
        else          r_req_q <= i_req;
    end

    assign w_set = i_req & ~r_req_q;
`else
    assign w_set = i_req;
`endif

    // A capture in the same cycle as the clear wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)   r_pend <= 1'b0;
        else if (w_set) r_pend <= 1'b1;
        else if (i_clr) r_pend <= 1'b0;
    end

    assign o_pend = r_pend;
endmodule

module irq_pending_dispatch #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_mask,
    output logic [N-1:0]   o_enc_i,
    input  logic           i_enc_v,
    input  logic [IDW-1:0] i_enc_y,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [IDW-1:0] o_out_id,
    output logic           o_busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_out_id;
    logic [N-1:0]     w_pend;
    logic [N-1:0]     w_clr;
    logic             w_accept;

    for (genvar k = 0; k < N; k++) begin : g_line
        assign w_clr[k] = w_accept && (r_out_id == IDW'(k));

        irq_pending_cell u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_req   (i_req[k]),
            .i_clr   (w_clr[k]),
            .o_pend  (w_pend[k])
        );
    end

    assign o_enc_i = w_pend & i_mask;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_enc_v) w_next = OFFER;
            OFFER:   if (i_out_ready) w_next = SETTLE;
            SETTLE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_out_valid = (r_state == OFFER);
        o_busy      = (r_state != IDLE);
        w_accept    = (r_state == OFFER) && i_out_ready;
    end

    // Encoder index is only sampled in IDLE, so the offered ID is frozen during OFFER.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                      r_out_id <= '0;
        else if (r_state == IDLE && i_enc_v) r_out_id <= i_enc_y;
    end

    assign o_out_id = r_out_id;
endmodule

// File: tb/tb_irq_pending_dispatch.sv
// Directed and randomized checks of irq_pending_dispatch against a transaction-level model.
module tb_irq_pending_dispatch;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   mask;
    logic [N-1:0]   enc_i;
    logic           enc_v;
    logic [IDW-1:0] enc_y;
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] out_id;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: set of pending lines plus the current offer and bubble countdown.
    logic [N-1:0]   m_pend = '0;
    logic [N-1:0]   m_prev = '0;
    bit             m_offer = 1'b0;
    logic [IDW-1:0] m_id = '0;
    int             m_cool = 0;

    always #5 clk = ~clk;

    irq_pending_dispatch #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_mask      (mask),
        .o_enc_i     (enc_i),
        .i_enc_v     (enc_v),
        .i_enc_y     (enc_y),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_id    (out_id),
        .o_busy      (busy)
    );

    // Generic priority encoder: highest set index wins.
    always_comb begin
        enc_v = |enc_i;
        enc_y = '0;
        for (int k = 0; k < N; k++)
            if (enc_i[k]) enc_y = IDW'(k);
    end

    function automatic logic [IDW-1:0] highest(input logic [N-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--)
            if (v[k]) begin
                r = IDW'(k);
                break;
            end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0] cap;
        logic [N-1:0] clr;
        if (!rst_n) begin
            m_pend  = '0;
            m_prev  = '0;
            m_offer = 1'b0;
            m_id    = '0;
            m_cool  = 0;
        end else begin
            cap = EDGE ? (req & ~m_prev) : req;
            clr = '0;
            if (m_offer) begin
                if (out_ready) begin
                    clr[m_id] = 1'b1;
                    m_offer   = 1'b0;
                    m_cool    = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if ((m_pend & mask) != '0) begin
                m_offer = 1'b1;
                m_id    = highest(m_pend & mask);
            end
            m_pend = (m_pend & ~clr) | cap;
            m_prev = req;
        end
        @(posedge clk);
        @(negedge clk);
        chk("model_valid", 32'(out_valid), 32'(m_offer));
        chk("model_busy", 32'(busy), 32'(m_offer || m_cool > 0));
        chk("model_enc_i", 32'(enc_i), 32'(m_pend & mask));
        if (m_offer) chk("model_out_id", 32'(out_id), 32'(m_id));
    endtask

    task automatic wait_offer(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        req = '0;
        repeat (5) tick();
    endtask

    initial begin
        int ids[$];
        int cyc[$];
        int offers;

        // Reset with every line requesting
        rst_n = 1'b0; req = 4'hF; mask = 4'hF; out_ready = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_enc_i", 32'(enc_i), 32'd0);
            chk("rst_out_id", 32'(out_id), 32'd0);
        end
        rst_n = 1'b1; req = '0;
        repeat (2) tick();

        // Single request: offered two cycles after the pulse, one beat
        req = 4'b0100;
        tick();
        chk("single_not_yet", 32'(out_valid), 32'd0);
        req = '0;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_id", 32'(out_id), 32'd2);
        tick();
        chk("single_one_beat", 32'(out_valid), 32'd0);
        chk("single_settle_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        chk("single_cleared", 32'(enc_i), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // Priority: 3,1,0 spaced three cycles apart
        req = 4'b1011;
        tick();
        req = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid) begin
                ids.push_back(int'(out_id));
                cyc.push_back(i);
            end
        end
        chk("prio_count", 32'(ids.size()), 32'd3);
        if (ids.size() == 3) begin
            chk("prio_id0", 32'(ids[0]), 32'd3);
            chk("prio_id1", 32'(ids[1]), 32'd1);
            chk("prio_id2", 32'(ids[2]), 32'd0);
            chk("prio_cyc0", 32'(cyc[0]), 32'd1);
            chk("prio_cyc1", 32'(cyc[1]), 32'd4);
            chk("prio_cyc2", 32'(cyc[2]), 32'd7);
        end
        drain();

        // Backpressure with mask dropping the offered line
        out_ready = 1'b0;
        req = 4'b1000;
        tick();
        req = '0;
        wait_offer("bp_timeout");
        chk("bp_id", 32'(out_id), 32'd3);
        mask = 4'h0;
        repeat (5) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_id", 32'(out_id), 32'd3);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accepted", 32'(out_valid), 32'd0);
        mask = 4'hF;
        tick();
        chk("bp_cleared", 32'(enc_i), 32'd0);
        drain();

        // Collision: re-capture in the acceptance cycle keeps the line pending
        req = 4'b0010;
        tick();
        req = '0;
        wait_offer("coll_timeout");
        chk("coll_first_id", 32'(out_id), 32'd1);
        req = 4'b0010;
        tick();
        req = '0;
        chk("coll_accept", 32'(out_valid), 32'd0);
        chk("coll_still_pending", 32'(enc_i), 32'b0010);
        repeat (2) tick();
        chk("coll_reoffer", 32'(out_valid), 32'd1);
        chk("coll_reoffer_id", 32'(out_id), 32'd1);
        drain();

        // Held line: one offer per edge, or continuous re-offers in level mode
        offers = 0;
        req = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) req = '0;
            tick();
            if (out_valid && out_ready) offers++;
        end
        chk("held_offers", 32'(offers), EDGE ? 32'd1 : 32'd4);
        drain();

        // Reset asserted mid-offer drops the ID without clearing through the handshake
        out_ready = 1'b0;
        req = 4'b0001;
        tick();
        req = '0;
        wait_offer("rstmid_timeout");
        rst_n = 1'b0;
        tick();
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_pending", 32'(enc_i), 32'd0);
        chk("rstmid_id", 32'(out_id), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            mask      = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'hF;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
